// File: rtl/paula_serial.sv
// paula_serial: Paula UART with SERDAT/SERPER/SERDATR registers,
// transmit buffer + shifter, receive shifter + buffer, irq strobes.
module paula_serial #(
    parameter logic [8:0] SERDATR = 9'h018,
    parameter logic [8:0] SERDAT  = 9'h030,
    parameter logic [8:0] SERPER  = 9'h032
) (
    input  logic        clk,
    input  logic        clk7_en,
    input  logic        reset,
    input  logic [8:1]  reg_address_in,
    input  logic [15:0] data_in,
    output logic [15:0] data_out,
    input  logic        rxd,
    output logic        txd,
    input  logic        rbfmirror,
    output logic        txint,
    output logic        rxint
);

    typedef enum logic [1:0] {
        TX_IDLE  = 2'd0,
        TX_START = 2'd1,
        TX_DATA  = 2'd2
    } tx_state_t;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2
    } rx_state_t;

    logic [14:0] per;
    logic        long_frame;
    logic [9:0]  txbuf;
    logic        tbe;
    logic        tsre;
    logic [9:0]  rxbuf;
    logic        ovrun;

    logic        wr_serdat;
    logic        wr_serper;
    logic        rd_serdatr;
    logic [3:0]  last_idx;

    tx_state_t   tx_state;
    tx_state_t   tx_next;
    logic [14:0] tx_cnt;
    logic [9:0]  tx_shift;
    logic [3:0]  tx_idx;
    logic        tx_expire;
    logic        tx_last;
    logic        tx_load;
    logic        tx_first;
    logic        tx_adv;
    logic        tx_finish;

    rx_state_t   rx_state;
    rx_state_t   rx_next;
    logic        rx_meta;
    logic        rxs;
    logic        rx_prev;
    logic        rx_fall;
    logic [14:0] rx_cnt;
    logic [3:0]  rx_idx;
    logic [8:0]  rx_shift;
    logic [9:0]  rx_word;
    logic        rx_expire;
    logic        rx_last;
    logic        rx_arm;
    logic        rx_go;
    logic        rx_samp;
    logic        rx_store;

    assign wr_serdat  = (reg_address_in == SERDAT[8:1]);
    assign wr_serper  = (reg_address_in == SERPER[8:1]);
    assign rd_serdatr = (reg_address_in == SERDATR[8:1]);
    assign last_idx   = long_frame ? 4'd9 : 4'd8;

    assign tx_expire = (tx_cnt == 15'd0);
    assign tx_last   = (tx_idx == last_idx);

    assign rx_fall   = rx_prev & ~rxs;
    assign rx_expire = (rx_cnt == 15'd0);
    assign rx_last   = (rx_idx == last_idx);
    assign rx_word   = {rxs, rx_shift};

    // Software-visible registers; a SERDAT write beats a shifter load on tbe.
    always_ff @(posedge clk) begin
        if (clk7_en) begin
            if (reset) begin
                per        <= 15'd0;
                long_frame <= 1'b0;
                txbuf      <= 10'd0;
                tbe        <= 1'b1;
                tsre       <= 1'b1;
            end else begin
                if (wr_serper) begin
                    per        <= data_in[14:0];
                    long_frame <= data_in[15];
                end
                if (wr_serdat) begin
                    txbuf <= data_in[9:0];
                    tbe   <= 1'b0;
                end else if (tx_load) begin
                    tbe <= 1'b1;
                end
                if (tx_load) begin
                    tsre <= 1'b0;
                end else if (tx_finish) begin
                    tsre <= 1'b1;
                end
            end
        end
    end

    // TX state register.
    always_ff @(posedge clk) begin
        if (clk7_en) begin
            if (reset) begin
                tx_state <= TX_IDLE;
            end else begin
                tx_state <= tx_next;
            end
        end
    end

    // TX next state: frames chain back-to-back while the buffer is full.
    always_comb begin
        tx_next = tx_state;
        case (tx_state)
            TX_IDLE:  if (!tbe) tx_next = TX_START;
            TX_START: if (tx_expire) tx_next = TX_DATA;
            TX_DATA: begin
                if (tx_expire && tx_last)
                    tx_next = tbe ? TX_IDLE : TX_START;
            end
            default:  tx_next = TX_IDLE;
        endcase
    end

    // TX strobes decoded from state and bit-counter expiry.
    always_comb begin
        tx_load   = 1'b0;
        tx_first  = 1'b0;
        tx_adv    = 1'b0;
        tx_finish = 1'b0;
        case (tx_state)
            TX_IDLE:  tx_load  = !tbe;
            TX_START: tx_first = tx_expire;
            TX_DATA: begin
                tx_adv    = tx_expire && !tx_last;
                tx_load   = tx_expire && tx_last && !tbe;
                tx_finish = tx_expire && tx_last && tbe;
            end
            default: ;
        endcase
    end

    // TX shifter, bit counter and registered line; per reloads at bit edges.
    always_ff @(posedge clk) begin
        if (clk7_en) begin
            if (reset) begin
                txd      <= 1'b1;
                txint    <= 1'b0;
                tx_cnt   <= 15'd0;
                tx_shift <= 10'd0;
                tx_idx   <= 4'd0;
            end else begin
                txint <= tx_load;
                if (tx_load) begin
                    tx_shift <= txbuf;
                    tx_cnt   <= per;
                    txd      <= 1'b0;
                end else if (tx_first || tx_adv) begin
                    txd      <= tx_shift[0];
                    tx_shift <= {1'b0, tx_shift[9:1]};
                    tx_cnt   <= per;
                    tx_idx   <= tx_first ? 4'd0 : tx_idx + 4'd1;
                end else if (tx_finish) begin
                    txd <= 1'b1;
                end else if (!tx_expire) begin
                    tx_cnt <= tx_cnt - 15'd1;
                end
            end
        end
    end

    // Two-flop synchroniser for rxd plus a delayed copy for edge detection.
    always_ff @(posedge clk) begin
        if (clk7_en) begin
            if (reset) begin
                rx_meta <= 1'b1;
                rxs     <= 1'b1;
                rx_prev <= 1'b1;
            end else begin
                rx_meta <= rxd;
                rxs     <= rx_meta;
                rx_prev <= rxs;
            end
        end
    end

    // RX state register.
    always_ff @(posedge clk) begin
        if (clk7_en) begin
            if (reset) begin
                rx_state <= RX_IDLE;
            end else begin
                rx_state <= rx_next;
            end
        end
    end

    // RX next state: half-period check rejects glitches as false starts.
    always_comb begin
        rx_next = rx_state;
        case (rx_state)
            RX_IDLE:  if (rx_fall) rx_next = RX_START;
            RX_START: if (rx_expire) rx_next = rxs ? RX_IDLE : RX_DATA;
            RX_DATA:  if (rx_expire && rx_last) rx_next = RX_IDLE;
            default:  rx_next = RX_IDLE;
        endcase
    end

    // RX strobes decoded from state and counter expiry.
    always_comb begin
        rx_arm   = 1'b0;
        rx_go    = 1'b0;
        rx_samp  = 1'b0;
        rx_store = 1'b0;
        case (rx_state)
            RX_IDLE:  rx_arm = rx_fall;
            RX_START: rx_go  = rx_expire && !rxs;
            RX_DATA: begin
                rx_samp  = rx_expire;
                rx_store = rx_expire && rx_last;
            end
            default: ;
        endcase
    end

    // RX counter, sample shifter, receive buffer and overrun flag.
    always_ff @(posedge clk) begin
        if (clk7_en) begin
            if (reset) begin
                rx_cnt   <= 15'd0;
                rx_idx   <= 4'd0;
                rx_shift <= 9'd0;
                rxbuf    <= 10'd0;
                rxint    <= 1'b0;
                ovrun    <= 1'b0;
            end else begin
                rxint <= rx_store;
                if (rx_arm) begin
                    rx_cnt <= {1'b0, per[14:1]};
                end else if (rx_go || (rx_samp && !rx_last)) begin
                    rx_cnt <= per;
                end else if (!rx_expire) begin
                    rx_cnt <= rx_cnt - 15'd1;
                end
                if (rx_go) begin
                    rx_idx <= 4'd0;
                end else if (rx_samp) begin
                    rx_idx <= rx_idx + 4'd1;
                end
                if (rx_samp) begin
                    rx_shift <= rx_word[9:1];
                end
                if (rx_store) begin
                    rxbuf <= long_frame ? rx_word : {1'b0, rx_word[9:1]};
                end
                if (!rbfmirror) begin
                    ovrun <= 1'b0;
                end else if (rx_store) begin
                    ovrun <= 1'b1;
                end
            end
        end
    end

    // SERDATR read mux.
    always_comb begin
        data_out = 16'h0000;
        if (rd_serdatr)
            data_out = {ovrun, rbfmirror, tbe, tsre, rxs, 1'b0, rxbuf};
    end

endmodule

// File: tb/tb_paula_serial.sv
// tb_paula_serial: vector tables, hand sequences and randomized
// TX/RX traffic checked against a frame-level reference model.
module tb_paula_serial;

    localparam logic [7:0] A_DATR = 8'h0C;
    localparam logic [7:0] A_DAT  = 8'h18;
    localparam logic [7:0] A_PER  = 8'h19;

    logic        clk = 1'b0;
    logic        clk7_en = 1'b1;
    logic        reset = 1'b1;
    logic [8:1]  addr = A_DATR;
    logic [15:0] din = 16'h0000;
    logic [15:0] dout;
    logic        rxd = 1'b1;
    logic        txd;
    logic        rbf = 1'b0;
    logic        txint;
    logic        rxint;

    paula_serial dut (
        .clk            (clk),
        .clk7_en        (clk7_en),
        .reset          (reset),
        .reg_address_in (addr),
        .data_in        (din),
        .data_out       (dout),
        .rxd            (rxd),
        .txd            (txd),
        .rbfmirror      (rbf),
        .txint          (txint),
        .rxint          (rxint)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] per_w;
        logic [15:0] dat;
        logic [10:0] wave;
        int          nb;
    } txv_t;

    typedef struct {
        logic [15:0] per_w;
        logic [9:0]  word;
        logic [9:0]  exp;
    } rxv_t;

    int          n_chk = 0;
    int          n_fail = 0;
    int          tnow = 0;
    int          rx_cnt = 0;
    int          tx_cnt = 0;
    int          tx_last_t = -1;
    int          tx_prev_t = -1;
    logic        rx_prev_int = 1'b0;
    logic [15:0] rx_snap = 16'h0000;

    task automatic chk1(input string name, input logic act, input logic exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b (tick %0d)", name, act, exp, tnow);
        end
    endtask

    task automatic chkw(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (tick %0d)", name, act, exp, tnow);
        end
    endtask

    task automatic chki(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (tick %0d)", name, act, exp, tnow);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        tnow++;
        if (txint) begin
            tx_cnt++;
            tx_prev_t = tx_last_t;
            tx_last_t = tnow;
        end
        if (rxint) begin
            chk1("rxint_width", rx_prev_int, 1'b0);
            rx_cnt++;
            rx_snap = dout;
        end
        rx_prev_int = rxint;
    endtask

    task automatic wr(input logic [7:0] a, input logic [15:0] d);
        addr = a;
        din  = d;
        tick();
        addr = A_DATR;
        din  = 16'h0000;
    endtask

    task automatic send_rx(input int p, input int nb, input logic [9:0] w);
        rxd = 1'b0;
        repeat (p + 1) tick();
        for (int i = 0; i < nb; i++) begin
            rxd = w[i];
            repeat (p + 1) tick();
        end
        rxd = 1'b1;
        repeat (p + 8) tick();
    endtask

    txv_t txv[5];
    rxv_t rxv[5];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        txv[0] = '{16'h0003, 16'h0155, 11'h2AA, 10};
        txv[1] = '{16'h0000, 16'h01FF, 11'h3FE, 10};
        txv[2] = '{16'h8001, 16'h03A5, 11'h74A, 11};
        txv[3] = '{16'h0002, 16'hFF01, 11'h202, 10};
        txv[4] = '{16'h8005, 16'h0200, 11'h400, 11};

        rxv[0] = '{16'h0003, 10'h1A5, 10'h1A5};
        rxv[1] = '{16'h8003, 10'h3A5, 10'h3A5};
        rxv[2] = '{16'h0002, 10'h3C3, 10'h1C3};
        rxv[3] = '{16'h8005, 10'h001, 10'h001};
        rxv[4] = '{16'h0001, 10'h15A, 10'h15A};

        // reset state
        reset = 1'b1;
        repeat (2) tick();
        chk1("rst_txd", txd, 1'b1);
        chk1("rst_txint", txint, 1'b0);
        chk1("rst_rxint", rxint, 1'b0);
        chkw("rst_serdatr", dout, 16'h3800);
        reset = 1'b0;
        tick();

        // TX vector table
        for (int v = 0; v < 5; v++) begin
            int p;
            p = int'(txv[v].per_w[14:0]);
            wr(A_PER, txv[v].per_w);
            wr(A_DAT, txv[v].dat);
            tick();
            chk1("tx_txint", txint, 1'b1);
            chk1("tx_start", txd, 1'b0);
            chk1("tx_tsre_busy", dout[12], 1'b0);
            chk1("tx_tbe_free", dout[13], 1'b1);
            for (int j = 1; j < txv[v].nb * (p + 1); j++) begin
                tick();
                chk1("tx_bit", txd, txv[v].wave[j / (p + 1)]);
                if (j == 1) chk1("txint_width", txint, 1'b0);
            end
            tick();
            chk1("tx_end_txd", txd, 1'b1);
            chk1("tx_end_tsre", dout[12], 1'b1);
            repeat (3) tick();
        end

        // back-to-back frames plus a write colliding with the reload
        begin
            logic [10:0] wv;
            int f;
            wr(A_PER, 16'h0003);
            wr(A_DAT, 16'h01FF);
            tick();
            chk1("b2b_txint0", txint, 1'b1);
            for (int j = 1; j <= 120; j++) begin
                addr = (j == 5 || j == 40) ? A_DAT : A_DATR;
                din  = (j == 5) ? 16'h0100 : 16'h00AA;
                tick();
                f  = j / 40;
                wv = (f == 0) ? 11'h3FE : (f == 1) ? 11'h200 : 11'h154;
                if (j < 120) begin
                    chk1("b2b_txd", txd, wv[(j % 40) / 4]);
                    chk1("b2b_txint", txint, (j % 40) == 0);
                end else begin
                    chk1("b2b_idle_txd", txd, 1'b1);
                    chk1("b2b_idle_tsre", dout[12], 1'b1);
                end
                if (j == 6 || j == 41) chk1("b2b_tbe_pending", dout[13], 1'b0);
                if (j == 40) chki("b2b_gap", tx_last_t - tx_prev_t, 40);
            end
            addr = A_DATR;
            din  = 16'h0000;
            repeat (3) tick();
        end

        // reset in the middle of TX and RX frames
        begin
            int rc0;
            wr(A_DAT, 16'h0155);
            rxd = 1'b0;
            repeat (9) tick();
            rxd = 1'b1;
            reset = 1'b1;
            tick();
            chk1("rstmid_txd", txd, 1'b1);
            chk1("rstmid_txint", txint, 1'b0);
            chk1("rstmid_tbe", dout[13], 1'b1);
            chk1("rstmid_tsre", dout[12], 1'b1);
            chkw("rstmid_serdatr", dout, 16'h3800);
            reset = 1'b0;
            rc0 = rx_cnt;
            repeat (60) tick();
            chki("rstmid_no_rxint", rx_cnt - rc0, 0);
            chk1("rstmid_txd_idle", txd, 1'b1);
        end

        // RX vector table
        for (int v = 0; v < 5; v++) begin
            int rc0;
            wr(A_PER, rxv[v].per_w);
            rc0 = rx_cnt;
            send_rx(int'(rxv[v].per_w[14:0]), rxv[v].per_w[15] ? 10 : 9, rxv[v].word);
            chki("rx_count", rx_cnt - rc0, 1);
            chkw("rx_word", {6'b0, rx_snap[9:0]}, {6'b0, rxv[v].exp});
            chk1("rx_no_ovrun", rx_snap[15], 1'b0);
        end

        // false start then a good frame
        begin
            int rc0;
            wr(A_PER, 16'h0007);
            rc0 = rx_cnt;
            rxd = 1'b0;
            tick();
            rxd = 1'b1;
            repeat (30) tick();
            chki("false_start", rx_cnt - rc0, 0);
            send_rx(7, 9, 10'h1A5);
            chki("after_false_count", rx_cnt - rc0, 1);
            chkw("after_false_word", {6'b0, rx_snap[9:0]}, 16'h01A5);
        end

        // overrun
        begin
            int rc0;
            wr(A_PER, 16'h0003);
            rbf = 1'b1;
            rc0 = rx_cnt;
            send_rx(3, 9, 10'h0F0);
            chki("ovr_count", rx_cnt - rc0, 1);
            chk1("ovr_flag_at_int", rx_snap[15], 1'b1);
            chk1("ovr_rbf_mirror", rx_snap[14], 1'b1);
            chk1("ovr_flag_held", dout[15], 1'b1);
            rbf = 1'b0;
            tick();
            chk1("ovr_cleared", dout[15], 1'b0);
            chk1("ovr_rbf_low", dout[14], 1'b0);
        end

        // randomized TX against a frame-level model
        for (int trial = 0; trial < 4; trial++) begin
            int p;
            int nb;
            int fstart;
            int fend;
            int bi;
            logic lg;
            logic act;
            logic pv;
            logic ei;
            logic ed;
            logic [9:0] pend;
            logic [9:0] fw;
            p  = $urandom_range(0, 3);
            lg = 1'($urandom_range(0, 1));
            wr(A_PER, {lg, 15'(p)});
            nb     = lg ? 11 : 10;
            act    = 1'b0;
            pv     = 1'b0;
            fstart = 0;
            fend   = 0;
            pend   = 10'd0;
            fw     = 10'd0;
            for (int t = 0; t < 400; t++) begin
                logic w;
                logic [15:0] wd;
                w    = (t < 300) && ($urandom_range(0, 29) == 0);
                wd   = 16'($urandom);
                addr = w ? A_DAT : A_DATR;
                din  = wd;
                tick();
                ei = 1'b0;
                if (act && t == fend) act = 1'b0;
                if (!act && pv) begin
                    act    = 1'b1;
                    fstart = t;
                    fend   = t + nb * (p + 1);
                    fw     = pend;
                    pv     = 1'b0;
                    ei     = 1'b1;
                end
                if (w) begin
                    pend = wd[9:0];
                    pv   = 1'b1;
                end
                bi = (t - fstart) / (p + 1);
                ed = !act ? 1'b1 : (bi == 0) ? 1'b0 : fw[bi - 1];
                chk1("rnd_txd", txd, ed);
                chk1("rnd_txint", txint, ei);
                if (!w) begin
                    chk1("rnd_tbe", dout[13], !pv);
                    chk1("rnd_tsre", dout[12], !act);
                end
            end
            addr = A_DATR;
            din  = 16'h0000;
        end

        // randomized RX frames
        for (int k = 0; k < 4; k++) begin
            int p;
            int rc0;
            logic lg;
            logic [9:0] w;
            logic [9:0] e;
            p  = $urandom_range(1, 5);
            lg = 1'($urandom_range(0, 1));
            w  = 10'($urandom);
            e  = lg ? w : {1'b0, w[8:0]};
            wr(A_PER, {lg, 15'(p)});
            rc0 = rx_cnt;
            send_rx(p, lg ? 10 : 9, w);
            chki("rnd_rx_count", rx_cnt - rc0, 1);
            chkw("rnd_rx_word", {6'b0, rx_snap[9:0]}, {6'b0, e});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
